// File: rtl/hog_bridge_pkg.sv
// rtl/hog_bridge_pkg.sv - register map, bit indices and bus FSM encoding for hog_bridge_ctrl
package hog_bridge_pkg;

    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_IRQ_MASK = 2;
    localparam int REG_IRQ_STAT = 3;
    localparam int REG_FIFO_POP = 4;
    localparam int REG_TS_NOW   = 5;
    localparam int REG_TS_LAST  = 6;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_START_BIT = 1;
    localparam int CTRL_FLUSH_BIT = 2;

    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_EN_BIT    = 10;

    localparam int IRQ_FIFO_BIT  = 0;
    localparam int IRQ_FRAME_BIT = 1;
    localparam int IRQ_OVF_BIT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DECODE  = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } bus_state_t;

endpackage

// File: rtl/hog_desc_fifo.sv
// rtl/hog_desc_fifo.sv - synchronous descriptor FIFO with count, full/empty and flush
module hog_desc_fifo #(
    parameter int BUS_WIDTH  = 128,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [BUS_WIDTH-1:0]         push_data,
    input  logic                         pop,
    output logic [BUS_WIDTH-1:0]         pop_data,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    // Flush wins over both ports so a word arriving alongside it is discarded.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign full     = count == (PW + 1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hog_bridge_ctrl.sv
// rtl/hog_bridge_ctrl.sv - HPS bridge register/IRQ controller and HOG descriptor buffer (option: HOG_BRIDGE_TIMESTAMP_EN)
module hog_bridge_ctrl
    import hog_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int BUS_WIDTH  = 128,
    parameter int BUS_BYTES  = BUS_WIDTH / 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  bus_enable,
    input  logic                  r_wbar,
    input  logic [BUS_WIDTH-1:0]  write_data,
    input  logic [BUS_BYTES-1:0]  byte_enable,
    output logic [BUS_WIDTH-1:0]  read_data,
    output logic                  ack,
    output logic                  irq,
    input  logic [BUS_WIDTH-1:0]  desc_data,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic                  frame_done,
    output logic                  hog_enable,
    output logic                  hog_start
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_t            state;
    bus_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_rd;
    logic                  lat_be0;
    logic [2:0]            lat_wbits;
    logic [BUS_WIDTH-1:0]  rdata_q;
    logic [BUS_WIDTH-1:0]  rd_val;
    logic                  ctrl_en;
    logic                  start_q;
    logic                  flush_q;
    logic                  irq_q;
    logic [2:0]            irq_mask;
    logic [2:0]            irq_stat;
    logic [2:0]            irq_set;
    logic [2:0]            irq_clr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [CW-1:0]         fifo_count;
    logic [BUS_WIDTH-1:0]  fifo_head;
    logic                  decode;
    logic                  reg_wr;
    logic                  wr_ctrl;
    logic                  wr_mask;
    logic                  wr_stat;
    logic                  unused_bits;

    // Every control bit lives in byte 0, so only that slice of a write is kept.
    assign unused_bits = ^{write_data[BUS_WIDTH-1:3], byte_enable[BUS_BYTES-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        read_data = '0;
        case (state)
            ST_IDLE:    if (bus_enable) state_nxt = ST_DECODE;
            ST_DECODE:  state_nxt = ST_ACK;
            ST_ACK: begin
                ack       = 1'b1;
                read_data = rdata_q;
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: if (!bus_enable) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr  <= '0;
            lat_rd    <= 1'b0;
            lat_be0   <= 1'b0;
            lat_wbits <= '0;
        end else if (state == ST_IDLE && bus_enable) begin
            lat_addr  <= addr;
            lat_rd    <= r_wbar;
            lat_be0   <= byte_enable[0];
            lat_wbits <= write_data[2:0];
        end
    end

    assign decode   = state == ST_DECODE;
    assign reg_wr   = decode && !lat_rd && lat_be0;
    assign wr_ctrl  = reg_wr && lat_addr == ADDR_WIDTH'(REG_CTRL);
    assign wr_mask  = reg_wr && lat_addr == ADDR_WIDTH'(REG_IRQ_MASK);
    assign wr_stat  = reg_wr && lat_addr == ADDR_WIDTH'(REG_IRQ_STAT);
    assign fifo_pop = decode && lat_rd && lat_addr == ADDR_WIDTH'(REG_FIFO_POP) && !fifo_empty;

    assign fifo_push  = desc_valid && !fifo_full;
    assign desc_ready = !fifo_full;
    assign hog_enable = ctrl_en;
    assign hog_start  = start_q;
    assign irq        = irq_q;
    assign irq_clr    = wr_stat ? lat_wbits : 3'b000;

    always_comb begin
        irq_set                = '0;
        irq_set[IRQ_FIFO_BIT]  = !fifo_empty;
        irq_set[IRQ_FRAME_BIT] = frame_done;
        irq_set[IRQ_OVF_BIT]   = desc_valid && fifo_full;
    end

`ifdef HOG_BRIDGE_TIMESTAMP_EN
    logic [31:0] ts_now;
    logic [31:0] ts_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_now  <= '0;
            ts_last <= '0;
        end else begin
            ts_now <= ts_now + 32'd1;
            if (frame_done) ts_last <= ts_now;
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        case (lat_addr)
            ADDR_WIDTH'(REG_CTRL):     rd_val[CTRL_EN_BIT] = ctrl_en;
            ADDR_WIDTH'(REG_STATUS): begin
                rd_val[7:0]            = 8'(fifo_count);
                rd_val[STAT_EMPTY_BIT] = fifo_empty;
                rd_val[STAT_FULL_BIT]  = fifo_full;
                rd_val[STAT_EN_BIT]    = ctrl_en;
            end
            ADDR_WIDTH'(REG_IRQ_MASK): rd_val[2:0] = irq_mask;
            ADDR_WIDTH'(REG_IRQ_STAT): rd_val[2:0] = irq_stat;
            ADDR_WIDTH'(REG_FIFO_POP): rd_val = fifo_empty ? '0 : fifo_head;
`ifdef HOG_BRIDGE_TIMESTAMP_EN
            ADDR_WIDTH'(REG_TS_NOW):   rd_val[31:0] = ts_now;
            ADDR_WIDTH'(REG_TS_LAST):  rd_val[31:0] = ts_last;
`endif
            default:                   rd_val = '0;
        endcase
    end

    // Start only fires if the same write leaves the pipeline enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en  <= 1'b0;
            start_q  <= 1'b0;
            flush_q  <= 1'b0;
            irq_mask <= '0;
            irq_stat <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            start_q  <= wr_ctrl && lat_wbits[CTRL_START_BIT] && lat_wbits[CTRL_EN_BIT];
            flush_q  <= wr_ctrl && lat_wbits[CTRL_FLUSH_BIT];
            if (wr_ctrl) ctrl_en  <= lat_wbits[CTRL_EN_BIT];
            if (wr_mask) irq_mask <= lat_wbits;
            irq_stat <= irq_set | (irq_stat & ~irq_clr);
            irq_q    <= |(irq_stat & irq_mask);
            if (decode) rdata_q <= lat_rd ? rd_val : '0;
        end
    end

    hog_desc_fifo #(
        .BUS_WIDTH  (BUS_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_q),
        .push      (fifo_push),
        .push_data (desc_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_hog_bridge_ctrl.sv
// tb/tb_hog_bridge_ctrl.sv - directed self-checking bench for hog_bridge_ctrl
module tb_hog_bridge_ctrl;
    localparam int AW = 5;
    localparam int BW = 128;
    localparam int BB = 16;
    localparam int DEPTH = 8;

    localparam logic [AW-1:0] A_CTRL = 5'd0;
    localparam logic [AW-1:0] A_STATUS = 5'd1;
    localparam logic [AW-1:0] A_MASK = 5'd2;
    localparam logic [AW-1:0] A_STAT = 5'd3;
    localparam logic [AW-1:0] A_POP = 5'd4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic          bus_enable;
    logic          r_wbar;
    logic [BW-1:0] write_data;
    logic [BB-1:0] byte_enable;
    logic [BW-1:0] read_data;
    logic          ack;
    logic          irq;
    logic [BW-1:0] desc_data;
    logic          desc_valid;
    logic          desc_ready;
    logic          frame_done;
    logic          hog_enable;
    logic          hog_start;

    int            n_checks = 0;
    int            n_pass = 0;
    int            start_cnt = 0;
    int            ack_cnt = 0;
    int            last_lat;
    logic          last_irq;
    logic [BW-1:0] rd;
    int            s0;
    int            a0;

    always #5 clk = ~clk;

    hog_bridge_ctrl #(
        .ADDR_WIDTH (AW),
        .BUS_WIDTH  (BW),
        .BUS_BYTES  (BB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .bus_enable  (bus_enable),
        .r_wbar      (r_wbar),
        .write_data  (write_data),
        .byte_enable (byte_enable),
        .read_data   (read_data),
        .ack         (ack),
        .irq         (irq),
        .desc_data   (desc_data),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .frame_done  (frame_done),
        .hog_enable  (hog_enable),
        .hog_start   (hog_start)
    );

    always @(negedge clk) begin
        if (hog_start) start_cnt++;
        if (ack) ack_cnt++;
    end

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic bus_xfer(input logic is_rd, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                            input logic [BB-1:0] be, input logic fd_in_decode,
                            output logic [BW-1:0] rdat);
        logic got;
        got = 1'b0;
        rdat = '0;
        last_lat = 0;
        @(posedge clk); #1;
        addr = a; r_wbar = is_rd; write_data = wd; byte_enable = be; bus_enable = 1'b1;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(posedge clk); #1;
            frame_done = fd_in_decode && (i == 1);
            if (ack) begin
                got = 1'b1; last_lat = i; rdat = read_data; last_irq = irq;
            end
        end
        frame_done = 1'b0;
        bus_enable = 1'b0;
        check("ack_seen", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic bus_rd(input logic [AW-1:0] a, output logic [BW-1:0] rdat);
        bus_xfer(1'b1, a, '0, '0, 1'b0, rdat);
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [BW-1:0] wd, input logic [BB-1:0] be);
        logic [BW-1:0] dummy;
        bus_xfer(1'b0, a, wd, be, 1'b0, dummy);
    endtask

    task automatic pulse_frame_done();
        @(posedge clk); #1; frame_done = 1'b1;
        @(posedge clk); #1; frame_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; bus_enable = 1'b0; r_wbar = 1'b0; write_data = '0;
        byte_enable = '0; desc_data = '0; desc_valid = 1'b0; frame_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_ack", ack, 0);
        check("rst_irq", irq, 0);
        check("rst_hog_enable", hog_enable, 0);
        check("rst_hog_start", hog_start, 0);
        check("rst_read_data", read_data, 0);
        check("rst_desc_ready", desc_ready, 1);
        bus_rd(A_STATUS, rd);
        check("rst_status", rd, 128'h100);

        // enable + start
        s0 = start_cnt;
        bus_wr(A_CTRL, 128'h3, 16'h0001);
        check("ctrl_ack_latency", last_lat, 2);
        check("ctrl_hog_enable", hog_enable, 1);
        check("ctrl_start_pulses", start_cnt - s0, 1);
        bus_rd(A_STATUS, rd);
        check("status_enabled", rd, 128'h500);
        bus_rd(A_CTRL, rd);
        check("ctrl_readback", rd, 128'h1);

        // disable, then byte lane 1 only must change nothing
        bus_wr(A_CTRL, 128'h0, 16'h0001);
        check("ctrl_disable", hog_enable, 0);
        s0 = start_cnt;
        bus_wr(A_CTRL, 128'h3, 16'h0002);
        check("be1_ack_latency", last_lat, 2);
        check("be1_hog_enable", hog_enable, 0);
        check("be1_no_start", start_cnt - s0, 0);
        bus_wr(A_CTRL, 128'h2, 16'h0001);
        check("start_while_disabled", start_cnt - s0, 0);

        // three descriptors in, three out, then an empty pop
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; desc_valid = 1'b1; desc_data = BW'(8'hA1 + i);
        end
        @(posedge clk); #1; desc_valid = 1'b0;
        bus_rd(A_STATUS, rd);
        check("status_count3", rd, 128'h3);
        bus_rd(A_POP, rd); check("pop_a1", rd, 128'hA1);
        bus_rd(A_POP, rd); check("pop_a2", rd, 128'hA2);
        bus_rd(A_POP, rd); check("pop_a3", rd, 128'hA3);
        bus_rd(A_POP, rd); check("pop_empty", rd, 128'h0);
        bus_rd(A_STATUS, rd);
        check("status_drained", rd, 128'h100);
        bus_rd(A_STAT, rd);
        check("irq_stat_fifo_sticky", rd, 128'h1);
        bus_wr(A_STAT, 128'h7, 16'h0001);
        bus_rd(A_STAT, rd);
        check("irq_stat_cleared", rd, 128'h0);

        // overflow
        bus_wr(A_MASK, 128'h4, 16'h0001);
        for (int i = 0; i < 9; i++) begin
            desc_valid = 1'b1; desc_data = BW'(8'hB0 + i);
            @(posedge clk); #1;
            if (i == 6) check("ready_after_7", desc_ready, 1);
            if (i == 7) check("ready_after_8", desc_ready, 0);
        end
        desc_valid = 1'b0;
        bus_rd(A_STATUS, rd);
        check("status_full", rd, 128'h208);
        bus_rd(A_STAT, rd);
        check("irq_stat_ovf", rd, 128'h5);
        check("irq_ovf", irq, 1);
        bus_wr(A_STAT, 128'h4, 16'h0001);
        check("irq_lag_at_ack", last_irq, 1);
        check("irq_cleared", irq, 0);
        bus_rd(A_POP, rd);
        check("pop_after_full", rd, 128'hB0);
        bus_wr(A_CTRL, 128'h4, 16'h0001);
        bus_rd(A_STATUS, rd);
        check("status_flushed", rd, 128'h100);
        bus_wr(A_MASK, 128'h0, 16'h0001);
        bus_wr(A_STAT, 128'h7, 16'h0001);

        // frame_done vs W1C
        pulse_frame_done();
        bus_rd(A_STAT, rd);
        check("frame_done_set", rd, 128'h2);
        bus_xfer(1'b0, A_STAT, 128'h2, 16'h0001, 1'b1, rd);
        bus_rd(A_STAT, rd);
        check("set_beats_w1c", rd, 128'h2);
        bus_wr(A_STAT, 128'h2, 16'h0001);
        bus_rd(A_STAT, rd);
        check("w1c_frame", rd, 128'h0);

        // unmapped addresses
        bus_wr(5'd7, 128'hFF, 16'hFFFF);
        bus_rd(5'd7, rd);  check("unmapped_7", rd, 128'h0);
        bus_rd(5'd31, rd); check("unmapped_31", rd, 128'h0);

        // reset in the middle of an access
        bus_wr(A_CTRL, 128'h1, 16'h0001);
        bus_wr(A_MASK, 128'h2, 16'h0001);
        pulse_frame_done();
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_irq", irq, 1);
        check("pre_rst_enable", hog_enable, 1);
        a0 = ack_cnt;
        @(posedge clk); #1;
        addr = A_STATUS; r_wbar = 1'b1; bus_enable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", ack, 0);
        check("midrst_read_data", read_data, 0);
        check("midrst_irq", irq, 0);
        check("midrst_hog_enable", hog_enable, 0);
        check("midrst_hog_start", hog_start, 0);
        bus_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_ack", ack_cnt - a0, 0);
        bus_rd(A_STATUS, rd);
        check("post_rst_status", rd, 128'h100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hog_bridge_ctrl.md
Name: hog_bridge_ctrl

Overview:
- Memory-mapped control and result-buffer controller sitting between the HPS bridge_0 external bus (128-bit, 5-bit word address) and the HOG pipeline.
- Decodes bridge reads and writes into control, status and IRQ registers, and sequences HOG start/enable.
- Buffers HOG descriptor words in a small FIFO that software drains, and generates a maskable level interrupt.
- All logic runs on the single HOG/bridge clock.

Parameters:
- ADDR_WIDTH, 5: bridge word-address width.
- BUS_WIDTH, 128: bridge data width; also the descriptor width.
- BUS_BYTES, 16: BUS_WIDTH/8; byte-enable width.
- FIFO_DEPTH, 8: descriptor FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  ADDR_WIDTH  bridge word address.
- bus_enable  in  1  access request; held by the bridge until ack.
- r_wbar  in  1  1 = read, 0 = write.
- write_data  in  BUS_WIDTH  write payload.
- byte_enable  in  BUS_BYTES  per-byte write mask.
- read_data  out  BUS_WIDTH  read payload; valid only in the ack cycle.
- ack  out  1  one-cycle access-complete pulse.
- irq  out  1  level interrupt to the HPS.
- desc_data  in  BUS_WIDTH  HOG descriptor word.
- desc_valid  in  1  descriptor handshake valid.
- desc_ready  out  1  descriptor handshake ready; equals !fifo_full.
- frame_done  in  1  one-cycle pulse from HOG at end of frame.
- hog_enable  out  1  HOG pipeline enable (CTRL.bit0).
- hog_start  out  1  one-cycle start pulse.

Behaviour:
- Reset (async assert, sync deassert):
  - read_data=0, ack=0, irq=0, hog_enable=0, hog_start=0.
  - FIFO empty; desc_ready=1; all registers 0; FSM in IDLE.
- Register map (word addresses):
  - 0 CTRL: bit0 enable RW; bit1 start W1 (self-clearing pulse); bit2 flush W1.
  - 1 STATUS RO: [7:0] fifo count, bit8 empty, bit9 full, bit10 hog_enable.
  - 2 IRQ_MASK RW [2:0].
  - 3 IRQ_STAT: [2:0] sticky, write-1-to-clear. Bit0 = fifo non-empty (level, not clearable while non-empty). Bit1 = frame_done. Bit2 = overflow.
  - 4 FIFO_POP RO: read returns the head entry and pops it; reading while empty returns 0, no pop.
  - All other addresses: read 0, writes ignored; still acked.
- Writes apply only the bytes with byte_enable set. Control bits all sit in byte 0.
- Bus FSM:
  - IDLE: bus_enable=1 → DECODE, latching addr, r_wbar, data and byte_enable.
  - DECODE: perform the register read or write (and the FIFO pop) → ACK.
  - ACK: ack=1, read_data driven → RELEASE.
  - RELEASE: wait for bus_enable=0 → IDLE.
  - Fixed latency: ack is asserted 2 cycles after bus_enable is first sampled high.
  - Outside the ACK state, read_data=0.
- hog_start is a pulse in the cycle after a DECODE that writes CTRL.bit1=1. It is suppressed when enable=0 after that same write is applied.
- FIFO:
  - Push on desc_valid & desc_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - desc_valid while full sets IRQ_STAT.bit2; the word is dropped.
  - Flush empties the FIFO in the cycle after the write. Any push in that cycle is discarded.
- IRQ:
  - frame_done sets bit1.
  - If a set and a W1C hit in the same cycle, set wins.
  - irq = |(IRQ_STAT & IRQ_MASK), registered, so it lags by 1 cycle.
- Reset mid-access: the FSM returns to IDLE with no ack. The bridge must retry.

Optional Feature:
- Macro: HOG_BRIDGE_TIMESTAMP_EN.
- Defined:
  - Free-running 32-bit cycle counter, readable at address 5. It wraps at 2^32.
  - The counter value is latched on every frame_done and readable at address 6.
- Undefined: addresses 5 and 6 read 0; no counter logic.

Decomposition:
- Package hog_bridge_pkg: register address localparams (REG_CTRL … REG_TS_LAST), CTRL/IRQ bit indices, FSM state encoding.
- One sub-module: hog_desc_fifo.
  - Synchronous FIFO, parameters BUS_WIDTH and FIFO_DEPTH.
  - Outputs count, full and empty; supports flush.

Test Plan:
- Write CTRL=0x3 with byte_enable=0x0001 → hog_enable=1; one hog_start pulse; ack exactly 2 cycles after bus_enable rises; STATUS.bit10=1.
- Push 3 descriptors (0xA1, 0xA2, 0xA3) → STATUS count=3. Three FIFO_POP reads return A1, A2, A3. A fourth read returns 0 with count still 0.
- Push 9 words with FIFO_DEPTH=8 → desc_ready=0 after the 8th push; IRQ_STAT.bit2=1. With IRQ_MASK=0x4, irq=1. Writing IRQ_STAT=0x4 clears irq one cycle later.
- frame_done pulse in the same cycle as a W1C of bit1 → bit1 remains set.
- Write CTRL=0x3 with byte_enable=0x0002 → no register change, no hog_start pulse; access is still acked.
- Deassert rst_n during DECODE → no ack; all outputs 0. After release, a fresh read of STATUS returns 0x100.
